// File: rtl/bank_sc_req_arbiter_if.sv
// Request-side and controller-side bundles for the bank SRAM-controller arbiter.
// Signal suffixes follow the arbiter's point of view (_i into it, _o out of it).

interface bank_sc_req_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   req_valid_i;
  logic [NUM_CH-1:0]   req_ready_o;
  logic [3*NUM_CH-1:0] req_opcode_i;
  logic [7*NUM_CH-1:0] req_set_way_offset_i;
  logic [8*NUM_CH-1:0] req_wbuffer_id_i;
  logic [3*NUM_CH-1:0] req_rob_num_i;

  modport master (
    output req_valid_i, req_opcode_i, req_set_way_offset_i, req_wbuffer_id_i, req_rob_num_i,
    input  req_ready_o
  );
  modport slave (
    input  req_valid_i, req_opcode_i, req_set_way_offset_i, req_wbuffer_id_i, req_rob_num_i,
    output req_ready_o
  );
endinterface

interface bank_sc_isu_if;
  logic       isu_sc_valid_o;
  logic       isu_sc_ready_i;
  logic [1:0] isu_sc_channel_id_o;
  logic [2:0] isu_sc_opcode_o;
  logic [6:0] isu_sc_set_way_offset_o;
  logic [7:0] isu_sc_wbuffer_id_o;
  logic [2:0] isu_sc_xbar_rob_num_o;

  modport master (
    output isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_opcode_o,
           isu_sc_set_way_offset_o, isu_sc_wbuffer_id_o, isu_sc_xbar_rob_num_o,
    input  isu_sc_ready_i
  );
  modport slave (
    input  isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_opcode_o,
           isu_sc_set_way_offset_o, isu_sc_wbuffer_id_o, isu_sc_xbar_rob_num_o,
    output isu_sc_ready_i
  );
endinterface

// File: rtl/bank_sc_req_arbiter.sv
// Round-robin arbiter feeding one bank's SRAM controller with a single outstanding,
// registered request; drops illegal opcodes and watches for hung requests.

module bank_sc_req_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bank_sc_req_if.slave     req,
  bank_sc_isu_if.master    isu,
  output logic             illegal_op_o,
  output logic             hang_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
  localparam logic [1:0]      LAST_CH_C = 2'(NUM_CH - 1);

  state_e          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            valid_q, valid_d;
  logic [1:0]      ch_id_q, ch_id_d;
  logic [2:0]      opcode_q, opcode_d;
  logic [6:0]      swo_q, swo_d;
  logic [7:0]      wbuf_q, wbuf_d;
  logic [2:0]      rob_q, rob_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            illegal_q, illegal_d;
  logic            hang_q, hang_d;

  // Channels padded to four slots so a 2-bit wrap of rr_ptr equals a mod-NUM_CH search.
  logic       val_a  [4];
  logic [2:0] op_a   [4];
  logic [6:0] swo_a  [4];
  logic [7:0] wbuf_a [4];
  logic [2:0] rob_a  [4];

  logic       slot_free_s;
  logic       grant_vld_s;
  logic [1:0] grant_idx_s;
  logic [1:0] cand_s;
  logic       hit_s;
  logic       accept_s;
  logic       legal_s;
  logic [3:0] ready_s;

  for (genvar c = 0; c < 4; c++) begin : g_ch
    if (c < NUM_CH) begin : g_on
      assign val_a[c]  = req.req_valid_i[c];
      assign op_a[c]   = req.req_opcode_i[3*c +: 3];
      assign swo_a[c]  = req.req_set_way_offset_i[7*c +: 7];
      assign wbuf_a[c] = req.req_wbuffer_id_i[8*c +: 8];
      assign rob_a[c]  = req.req_rob_num_i[3*c +: 3];
    end else begin : g_off
      assign val_a[c]  = 1'b0;
      assign op_a[c]   = 3'd0;
      assign swo_a[c]  = 7'd0;
      assign wbuf_a[c] = 8'd0;
      assign rob_a[c]  = 3'd0;
    end
  end

  // Round-robin search starting at rr_ptr; first valid channel wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 2'd0;
    cand_s      = 2'd0;
    hit_s       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand_s      = rr_ptr_q + 2'(i);
      hit_s       = !grant_vld_s && val_a[cand_s];
      grant_idx_s = hit_s ? cand_s : grant_idx_s;
      grant_vld_s = grant_vld_s | hit_s;
    end
  end

  assign slot_free_s = (state_q == IDLE) | ((state_q == BUSY) & isu.isu_sc_ready_i);
  assign accept_s    = slot_free_s & grant_vld_s;
  assign legal_s     = ~op_a[grant_idx_s][2];
  assign ready_s     = accept_s ? (4'b0001 << grant_idx_s) : 4'b0000;

  // Next-state, payload capture and watchdog.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    valid_d   = valid_q;
    ch_id_d   = ch_id_q;
    opcode_d  = opcode_q;
    swo_d     = swo_q;
    wbuf_d    = wbuf_q;
    rob_d     = rob_q;
    illegal_d = illegal_q;
    wd_d      = wd_q;
    hang_d    = hang_q;

    if ((state_q == BUSY) && !isu.isu_sc_ready_i) begin
      wd_d   = (wd_q != TIMEOUT_C) ? wd_q + TO_W'(1) : wd_q;
      hang_d = hang_q | (wd_q == (TIMEOUT_C - TO_W'(1)));
    end else begin
      wd_d   = {TO_W{1'b0}};
      hang_d = hang_q;
    end

    case (state_q)
      IDLE, BUSY: begin
        if (accept_s) begin
          rr_ptr_d = (grant_idx_s == LAST_CH_C) ? 2'd0 : grant_idx_s + 2'd1;
          if (legal_s) begin
            state_d  = BUSY;
            valid_d  = 1'b1;
            ch_id_d  = grant_idx_s;
            opcode_d = op_a[grant_idx_s];
            swo_d    = swo_a[grant_idx_s];
            wbuf_d   = wbuf_a[grant_idx_s];
            rob_d    = rob_a[grant_idx_s];
          end else begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            illegal_d = 1'b1;
          end
        end else if ((state_q == BUSY) && isu.isu_sc_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = state_q;
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'd0;
      valid_q   <= 1'b0;
      ch_id_q   <= 2'd0;
      opcode_q  <= 3'd0;
      swo_q     <= 7'd0;
      wbuf_q    <= 8'd0;
      rob_q     <= 3'd0;
      wd_q      <= {TO_W{1'b0}};
      illegal_q <= 1'b0;
      hang_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      valid_q   <= valid_d;
      ch_id_q   <= ch_id_d;
      opcode_q  <= opcode_d;
      swo_q     <= swo_d;
      wbuf_q    <= wbuf_d;
      rob_q     <= rob_d;
      wd_q      <= wd_d;
      illegal_q <= illegal_d;
      hang_q    <= hang_d;
    end
  end

  assign req.req_ready_o             = ready_s[NUM_CH-1:0];
  assign isu.isu_sc_valid_o          = valid_q;
  assign isu.isu_sc_channel_id_o     = ch_id_q;
  assign isu.isu_sc_opcode_o         = opcode_q;
  assign isu.isu_sc_set_way_offset_o = swo_q;
  assign isu.isu_sc_wbuffer_id_o     = wbuf_q;
  assign isu.isu_sc_xbar_rob_num_o   = rob_q;
  assign illegal_op_o                = illegal_q;
  assign hang_o                      = hang_q;

endmodule

// File: tb/tb_bank_sc_req_arbiter.sv
// Directed and randomized bench for bank_sc_req_arbiter against a cycle-level
// reference model of the arbitration, handshake and watchdog rules.

module tb_bank_sc_req_arbiter;

  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 1024;
  localparam int TO_W    = 11;

  logic clk = 1'b0;
  logic rst;
  logic illegal_op;
  logic hang;

  always #5 clk = ~clk;

  bank_sc_req_if #(.NUM_CH(NUM_CH)) req_if ();
  bank_sc_isu_if                    isu_if ();

  bank_sc_req_arbiter #(
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req          (req_if.slave),
    .isu          (isu_if.master),
    .illegal_op_o (illegal_op),
    .hang_o       (hang)
  );

  // Requester side: each channel holds valid and payload until accepted.
  bit         pend [NUM_CH];
  logic [2:0] op   [NUM_CH];
  logic [6:0] swo  [NUM_CH];
  logic [7:0] wb   [NUM_CH];
  logic [2:0] rob  [NUM_CH];
  bit         refill;
  logic       sc_rdy;
  logic [NUM_CH-1:0] obs_rdy;

  // Reference model state.
  bit         m_busy;
  int         m_rr;
  int         m_wd;
  bit         m_ill;
  bit         m_hang;
  int         m_ch;
  logic [2:0] m_op;
  logic [6:0] m_swo;
  logic [7:0] m_wb;
  logic [2:0] m_rob;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic gen_req(input int c, input bit allow_ill);
    pend[c] = 1'b1;
    if (allow_ill && ($urandom_range(0, 7) == 0)) op[c] = 3'($urandom_range(4, 7));
    else op[c] = 3'($urandom_range(0, 3));
    swo[c] = 7'($urandom);
    wb[c]  = 8'($urandom);
    rob[c] = 3'($urandom);
  endtask

  task automatic drive();
    for (int c = 0; c < NUM_CH; c++) begin
      req_if.req_valid_i[c]                = pend[c];
      req_if.req_opcode_i[3*c +: 3]        = op[c];
      req_if.req_set_way_offset_i[7*c +: 7] = swo[c];
      req_if.req_wbuffer_id_i[8*c +: 8]    = wb[c];
      req_if.req_rob_num_i[3*c +: 3]       = rob[c];
    end
    isu_if.isu_sc_ready_i = sc_rdy;
  endtask

  // The slot is open when nothing is outstanding or the controller completes now.
  function automatic int model_pick();
    if (m_busy && !sc_rdy) return -1;
    for (int i = 0; i < NUM_CH; i++) begin
      int c = (m_rr + i) % NUM_CH;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_rr = 0; m_wd = 0; m_ill = 1'b0; m_hang = 1'b0;
    m_ch = 0; m_op = 3'd0; m_swo = 7'd0; m_wb = 8'd0; m_rob = 3'd0;
  endtask

  task automatic check_outputs();
    chk("isu_valid", 32'(isu_if.isu_sc_valid_o), 32'(m_busy));
    chk("isu_ch",    32'(isu_if.isu_sc_channel_id_o), m_ch);
    chk("isu_op",    32'(isu_if.isu_sc_opcode_o), 32'(m_op));
    chk("isu_swo",   32'(isu_if.isu_sc_set_way_offset_o), 32'(m_swo));
    chk("isu_wb",    32'(isu_if.isu_sc_wbuffer_id_o), 32'(m_wb));
    chk("isu_rob",   32'(isu_if.isu_sc_xbar_rob_num_o), 32'(m_rob));
    chk("illegal",   32'(illegal_op), 32'(m_ill));
    chk("hang",      32'(hang), 32'(m_hang));
  endtask

  // One clock: drive at edge+1, check handshake mid-cycle, advance model at the edge.
  task automatic step(input logic rdy);
    int g;
    logic [NUM_CH-1:0] exp_rdy;
    sc_rdy = rdy;
    drive();
    #3;
    g = model_pick();
    exp_rdy = (g >= 0) ? NUM_CH'(1 << g) : '0;
    obs_rdy = req_if.req_ready_o;
    chk("req_ready", 32'(obs_rdy), 32'(exp_rdy));
    @(posedge clk);
    if (m_busy && !sc_rdy) begin
      m_wd = (m_wd < TIMEOUT) ? m_wd + 1 : m_wd;
      if (m_wd == TIMEOUT) m_hang = 1'b1;
    end
    if (g >= 0) begin
      m_rr = (g + 1) % NUM_CH;
      if (op[g] >= 3'd4) begin
        m_ill  = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_busy = 1'b1; m_wd = 0; m_ch = g;
        m_op = op[g]; m_swo = swo[g]; m_wb = wb[g]; m_rob = rob[g];
      end
      if (refill) gen_req(g, 1'b0);
      else pend[g] = 1'b0;
    end else if (m_busy && sc_rdy) begin
      m_busy = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    for (int c = 0; c < NUM_CH; c++) pend[c] = 1'b0;
    refill = 1'b0;
    sc_rdy = 1'b0;
    drive();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_ready", 32'(req_if.req_ready_o), 32'd0);
    check_outputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int grants[$];
  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      pend[c] = 1'b0; op[c] = 3'd0; swo[c] = 7'd0; wb[c] = 8'd0; rob[c] = 3'd0;
    end
    refill = 1'b0;
    sc_rdy = 1'b0;
    drive();
    @(posedge clk);
    #1;

    // Single request on channel 2.
    do_reset();
    pend[2] = 1'b1; op[2] = 3'd1; swo[2] = 7'h15; wb[2] = 8'h3c; rob[2] = 3'd3;
    step(1'b0);
    chk("single_rdy", 32'(obs_rdy), 32'b0100);
    chk("single_valid", 32'(isu_if.isu_sc_valid_o), 32'd1);
    chk("single_ch", 32'(isu_if.isu_sc_channel_id_o), 32'd2);
    chk("single_swo", 32'(isu_if.isu_sc_set_way_offset_o), 32'h15);
    repeat (3) step(1'b0);
    chk("single_hold", 32'(isu_if.isu_sc_set_way_offset_o), 32'h15);
    step(1'b1);
    chk("single_done", 32'(isu_if.isu_sc_valid_o), 32'd0);

    // Round-robin with all channels requesting, completion on every third busy cycle.
    do_reset();
    refill = 1'b1;
    for (int c = 0; c < NUM_CH; c++) gen_req(c, 1'b0);
    for (int t = 0; t < 13; t++) begin
      step((t % 3) == 0 && t != 0);
      for (int c = 0; c < NUM_CH; c++) if (obs_rdy[c]) grants.push_back(c);
    end
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < grants.size()) ? grants[i] : -1, exp_rr[i]);

    // Back-to-back completion and grant.
    do_reset();
    gen_req(1, 1'b0);
    step(1'b0);
    gen_req(3, 1'b0);
    step(1'b0);
    chk("b2b_wait", 32'(obs_rdy), 32'd0);
    step(1'b1);
    chk("b2b_rdy", 32'(obs_rdy), 32'b1000);
    chk("b2b_valid", 32'(isu_if.isu_sc_valid_o), 32'd1);
    chk("b2b_ch", 32'(isu_if.isu_sc_channel_id_o), 32'd3);
    step(1'b1);

    // Illegal opcode consumed and flagged, next channel served normally.
    do_reset();
    gen_req(0, 1'b0);
    op[0] = 3'd5;
    gen_req(1, 1'b0);
    step(1'b0);
    chk("ill_rdy", 32'(obs_rdy), 32'b0001);
    chk("ill_valid", 32'(isu_if.isu_sc_valid_o), 32'd0);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    step(1'b0);
    chk("ill_next_rdy", 32'(obs_rdy), 32'b0010);
    chk("ill_next_ch", 32'(isu_if.isu_sc_channel_id_o), 32'd1);
    step(1'b1);

    // Watchdog expiry and stickiness.
    do_reset();
    gen_req(2, 1'b0);
    step(1'b0);
    repeat (TIMEOUT - 1) step(1'b0);
    chk("wd_pre", 32'(hang), 32'd0);
    step(1'b0);
    chk("wd_hang", 32'(hang), 32'd1);
    step(1'b1);
    chk("wd_sticky", 32'(hang), 32'd1);
    chk("wd_done", 32'(isu_if.isu_sc_valid_o), 32'd0);

    // Reset while busy, then the search restarts at channel 0.
    do_reset();
    gen_req(1, 1'b0);
    step(1'b0);
    do_reset();
    gen_req(0, 1'b0);
    gen_req(3, 1'b0);
    step(1'b0);
    chk("post_rst_rdy", 32'(obs_rdy), 32'b0001);
    step(1'b1);
    step(1'b1);

    // Randomized traffic, including illegal opcodes and idle-time ready pulses.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (!pend[c] && ($urandom_range(0, 3) == 0)) gen_req(c, 1'b1);
      step($urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bank_sc_req_arbiter.md
Name: bank_sc_req_arbiter

Overview:
- Round-robin arbiter in front of one bank's SRAM controller.
- Takes per-channel request ports and drives the single isu->sc request interface with a registered, stable payload until the controller signals completion.
- Keeps exactly one request outstanding at the controller; completion and the next grant can happen in the same cycle.
- Filters illegal opcodes and runs a hang watchdog on outstanding requests.

Parameters:
- NUM_CH, 4, number of requesting channels; channel id width is fixed at 2, so the maximum is 4.
- TIMEOUT, 1024, number of cycles a request may stay outstanding before hang_o is raised.
- TO_W, 11, watchdog counter width; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NUM_CH  per-channel request valid.
- req_ready_o  out  NUM_CH  per-channel accept; at most one bit high per cycle.
- req_opcode_i  in  3*NUM_CH  per-channel opcode: 0 WRITE, 1 READ, 2 READ_WITH_LINEFILL, 3 WRITE_BACK.
- req_set_way_offset_i  in  7*NUM_CH  per-channel SRAM address {set_way[5:0], offset}.
- req_wbuffer_id_i  in  8*NUM_CH  per-channel write-buffer id.
- req_rob_num_i  in  3*NUM_CH  per-channel xbar ROB number.
- isu_sc_valid_o  out  1  request valid to the controller; registered.
- isu_sc_ready_i  in  1  controller done pulse; combinational from the controller.
- isu_sc_channel_id_o  out  2  channel index of the granted request.
- isu_sc_opcode_o  out  3  registered payload field.
- isu_sc_set_way_offset_o  out  7  registered payload field.
- isu_sc_wbuffer_id_o  out  8  registered payload field.
- isu_sc_xbar_rob_num_o  out  3  registered payload field.
- illegal_op_o  out  1  sticky; set when an opcode of 4..7 is accepted.
- hang_o  out  1  sticky; set when the watchdog expires.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_ptr=0, isu_sc_valid_o=0, all payload outputs 0, watchdog=0, illegal_op_o=0, hang_o=0.
  - Reset mid-request drops the outstanding request silently; no replay.
- States: IDLE (nothing outstanding) and BUSY (isu_sc_valid_o=1, payload held).
- Slot free: slot_free = (state==IDLE) | (state==BUSY & isu_sc_ready_i).
- Arbitration:
  - When slot_free, search req_valid_i starting at rr_ptr and wrapping (rr_ptr, rr_ptr+1, ..., mod NUM_CH).
  - The first valid channel g gets req_ready_o[g]=1 combinationally in that cycle; this is the handshake (accept = valid & ready).
- Legal accept (opcode 0..3):
  - Next edge: channel id g and the payload fields load into the output registers, isu_sc_valid_o=1, state=BUSY, rr_ptr=(g+1) mod NUM_CH, watchdog=0.
  - Latency from accept to isu_sc_valid_o is 1 cycle.
- Illegal accept (opcode 4..7):
  - The request is consumed (req_ready_o pulses) but not forwarded.
  - illegal_op_o is set; rr_ptr advances as for a legal accept.
  - State becomes IDLE if the slot was freed by a completion, otherwise stays IDLE.
- BUSY:
  - Payload and isu_sc_valid_o are held stable; no req_ready_o unless isu_sc_ready_i=1.
  - isu_sc_ready_i=1 with no legal accept in the same cycle: next edge state=IDLE, isu_sc_valid_o=0.
  - isu_sc_ready_i=1 with a legal accept in the same cycle: back-to-back. State stays BUSY and the new payload is loaded, so the controller sees valid continuously with a new payload.
- isu_sc_ready_i in IDLE is ignored.
- Watchdog:
  - In BUSY without completion it increments, saturating at TIMEOUT.
  - hang_o is set on the edge where the count reaches TIMEOUT; it clears only on reset.
  - Arbitration is unaffected by hang_o.
- Fairness: a channel that keeps valid asserted is granted within NUM_CH grants.
- Channels whose valid is low are skipped with no penalty.
- req_ready_o never asserts for a channel whose valid is low.
- Requesters must hold valid and payload until accepted; the arbiter samples the payload only in the accept cycle.

Test Plan:
- Single request: reset, ch2 valid opcode=1 swo=7'h15 rob=3 -> req_ready_o=4'b0100 for 1 cycle; next cycle isu_sc_valid_o=1, channel_id=2, swo=7'h15; payload held until isu_sc_ready_i, then valid=0.
- Round-robin: ch0..ch3 all valid continuously, controller completes each request after 3 cycles -> grant order 0,1,2,3,0; rr_ptr wraps 3->0.
- Back-to-back: BUSY on ch1, ch3 valid, isu_sc_ready_i=1 -> req_ready_o[3]=1 that cycle; next cycle valid stays 1 with channel_id=3, no bubble.
- Illegal opcode: ch0 opcode=5 in IDLE -> req_ready_o[0]=1, isu_sc_valid_o stays 0, illegal_op_o=1 from next cycle; ch1 is then granted normally.
- Watchdog: grant, never assert isu_sc_ready_i -> hang_o=0 at cycle TIMEOUT-1 and 1 at cycle TIMEOUT after grant; remains 1 after a later completion.
- Reset mid-operation: assert rst_i while BUSY -> all outputs 0 immediately (asynchronously); after release, ch0 is checked first.
